// File: rtl/matmul_adder_tree_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : matmul_adder_tree_pipe_if
// Summary  : Product-beat input and result output bundle for the adder tree.
// Revision : 1.0
// ============================================================================
interface matmul_adder_tree_pipe_if #(
  parameter int DIM_M     = 3,
  parameter int DIM_K     = 3,
  parameter int DIM_N     = 3,
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 24
);
  logic                                                  in_valid;
  logic                                                  in_ready;
  logic [DIM_M*DIM_K-1:0][DIM_K*DIM_N-1:0][ACC_WIDTH-1:0] prod;
  logic                                                  in_last;
  logic                                                  accum_en;
  logic                                                  out_valid;
  logic                                                  out_ready;
  logic [DIM_M*DIM_N-1:0][OUT_WIDTH-1:0]                 mult;
  logic [DIM_M*DIM_N-1:0]                                sat_flag;
  logic [7:0]                                            beat_cnt;

  modport master (
    output in_valid, prod, in_last, accum_en, out_ready,
    input  in_ready, out_valid, mult, sat_flag, beat_cnt
  );

  modport slave (
    input  in_valid, prod, in_last, accum_en, out_ready,
    output in_ready, out_valid, mult, sat_flag, beat_cnt
  );
endinterface
`default_nettype wire

// File: rtl/matmul_adder_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : matmul_adder_tree_pipe
// Summary  : Pipelined adder-tree reduction of TLUT products to MxN dot
//            products, with K-tile accumulation and optional saturation.
// Revision : 1.0
// ============================================================================
module matmul_adder_tree_pipe #(
  parameter int DIM_M     = 3,
  parameter int DIM_K     = 3,
  parameter int DIM_N     = 3,
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 24,
  parameter bit SAT_EN    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  matmul_adder_tree_pipe_if.slave  bus
);

  localparam int c_dim_mn = DIM_M * DIM_N;
  localparam int c_k_log  = $clog2(DIM_K);
  localparam int c_tree_w = ACC_WIDTH + c_k_log;
  localparam int c_levels = (c_k_log < 1) ? 1 : c_k_log;
  localparam int c_sum_w  = ((OUT_WIDTH > c_tree_w) ? OUT_WIDTH : c_tree_w) + 1;

  // Operand count at tree level lvl (level 0 holds the DIM_K raw terms)
  function automatic int f_lvl_cnt(input int lvl);
    return (DIM_K + (1 << lvl) - 1) >> lvl;
  endfunction

  // Base index of level lvl (>= 1) inside the flattened node storage
  function automatic int f_lvl_off(input int lvl);
    int off;
    off = 0;
    for (int l = 1; l < lvl; l++) off += f_lvl_cnt(l);
    return off;
  endfunction

  localparam int c_nodes = f_lvl_off(c_levels + 1);
  localparam int c_root  = f_lvl_off(c_levels);

  localparam logic signed [OUT_WIDTH-1:0] c_out_max = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] c_out_min = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [c_sum_w-1:0]   c_sum_max = c_sum_w'(c_out_max);
  localparam logic signed [c_sum_w-1:0]   c_sum_min = c_sum_w'(c_out_min);

  logic w_en;
  logic w_accept;
  logic r_alive;

  logic [c_levels-1:0] r_vld;
  logic [c_levels-1:0] r_last;
  logic [c_levels-1:0] r_acc_en;

  logic signed [c_tree_w-1:0] w_term [c_dim_mn][DIM_K];
  logic signed [c_tree_w-1:0] r_node [c_dim_mn][c_nodes];

  logic signed [OUT_WIDTH-1:0]             r_acc [c_dim_mn];
  logic [c_dim_mn-1:0]                     r_sat_acc;
  logic [7:0]                              r_cnt;
  logic                                    r_fresh;
  logic                                    r_out_valid;
  logic [c_dim_mn-1:0][OUT_WIDTH-1:0]      r_mult;
  logic [c_dim_mn-1:0]                     r_sat_flag;
  logic [7:0]                              r_beat_cnt;

  logic signed [c_sum_w-1:0]   w_base [c_dim_mn];
  logic signed [c_sum_w-1:0]   w_add  [c_dim_mn];
  logic signed [c_sum_w-1:0]   w_sum  [c_dim_mn];
  logic signed [OUT_WIDTH-1:0] w_next [c_dim_mn];
  logic [c_dim_mn-1:0]         w_ovf;
  logic [c_dim_mn-1:0]         w_sat_next;
  logic [7:0]                  w_cnt_next;
  logic                        w_close;
  logic                        w_fire;

  // Off-diagonal product blocks carry no (i,k,j) term and are ignored
  logic w_unused_prod;
  assign w_unused_prod = ^bus.prod;

  assign w_en         = ~r_out_valid | bus.out_ready;
  assign bus.in_ready = r_alive & w_en;
  assign w_accept     = bus.in_valid & bus.in_ready;

  generate
    for (genvar i = 0; i < DIM_M; i++) begin : g_row
      for (genvar j = 0; j < DIM_N; j++) begin : g_col
        for (genvar k = 0; k < DIM_K; k++) begin : g_term
          assign w_term[i*DIM_N+j][k] =
            c_tree_w'($signed(bus.prod[i*DIM_K+k][k*DIM_N+j]));
        end
      end
    end
  endgenerate

  generate
    for (genvar l = 1; l <= c_levels; l++) begin : g_lvl
      localparam int c_cnt  = f_lvl_cnt(l);
      localparam int c_prev = f_lvl_cnt(l - 1);
      localparam int c_off  = f_lvl_off(l);
      for (genvar p = 0; p < c_cnt; p++) begin : g_node
        for (genvar e = 0; e < c_dim_mn; e++) begin : g_elem
          logic signed [c_tree_w-1:0] w_a;
          logic signed [c_tree_w-1:0] w_b;
          if (l == 1) begin : g_src_term
            assign w_a = w_term[e][2*p];
            if (2*p + 1 < c_prev) begin : g_pair
              assign w_b = w_term[e][2*p+1];
            end else begin : g_pass
              assign w_b = '0;
            end
          end else begin : g_src_node
            localparam int c_src = f_lvl_off(l - 1);
            assign w_a = r_node[e][c_src+2*p];
            if (2*p + 1 < c_prev) begin : g_pair
              assign w_b = r_node[e][c_src+2*p+1];
            end else begin : g_pass
              assign w_b = '0;
            end
          end

          always_ff @(posedge clk) begin
            if (w_en) r_node[e][c_off+p] <= w_a + w_b;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= '0;
      r_last   <= '0;
      r_acc_en <= '0;
      r_alive  <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (w_en) begin
        r_vld[0]    <= w_accept;
        r_last[0]   <= bus.in_last;
        r_acc_en[0] <= bus.accum_en;
        for (int l = 1; l < c_levels; l++) begin
          r_vld[l]    <= r_vld[l-1];
          r_last[l]   <= r_last[l-1];
          r_acc_en[l] <= r_acc_en[l-1];
        end
      end
    end
  end

  assign w_close = r_last[c_levels-1] | ~r_acc_en[c_levels-1];
  assign w_fire  = w_en & r_vld[c_levels-1];

  // Sum is formed one bit wider than either operand so overflow is visible
  always_comb begin
    for (int e = 0; e < c_dim_mn; e++) begin
      w_base[e] = '0;
      if (!r_fresh) w_base[e] = c_sum_w'(r_acc[e]);
      w_add[e] = c_sum_w'(r_node[e][c_root]);
      w_sum[e] = w_base[e] + w_add[e];
      w_ovf[e] = (w_sum[e] > c_sum_max) || (w_sum[e] < c_sum_min);
      if (SAT_EN && w_ovf[e])
        w_next[e] = w_sum[e][c_sum_w-1] ? c_out_min : c_out_max;
      else
        w_next[e] = w_sum[e][OUT_WIDTH-1:0];
    end
    w_sat_next = r_fresh ? w_ovf : (r_sat_acc | w_ovf);
    if (r_fresh)
      w_cnt_next = 8'd1;
    else if (r_cnt == 8'hFF)
      w_cnt_next = 8'hFF;
    else
      w_cnt_next = r_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < c_dim_mn; e++) r_acc[e] <= '0;
      r_sat_acc   <= '0;
      r_cnt       <= '0;
      r_fresh     <= 1'b1;
      r_out_valid <= 1'b0;
      r_mult      <= '0;
      r_sat_flag  <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (w_en) r_out_valid <= r_vld[c_levels-1] & w_close;
      if (w_fire) begin
        for (int e = 0; e < c_dim_mn; e++) r_acc[e] <= w_next[e];
        r_sat_acc <= w_sat_next;
        r_cnt     <= w_cnt_next;
        r_fresh   <= w_close;
        if (w_close) begin
          for (int e = 0; e < c_dim_mn; e++) r_mult[e] <= w_next[e];
          r_sat_flag <= w_sat_next;
          r_beat_cnt <= w_cnt_next;
        end
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.mult      = r_mult;
  assign bus.sat_flag  = r_sat_flag;
  assign bus.beat_cnt  = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_matmul_adder_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_adder_tree_pipe
// Summary  : Directed-vector bench for the pipelined product adder tree.
// Revision : 1.0
// ============================================================================
module tb_matmul_adder_tree_pipe;

  localparam int M   = 3;
  localparam int K   = 3;
  localparam int N   = 3;
  localparam int AW  = 16;
  localparam int OW  = 24;
  localparam int OWS = 20;

  typedef logic [M*K-1:0][K*N-1:0][AW-1:0] prod_t;
  typedef logic [M*N-1:0][OW-1:0]          mult_t;
  typedef logic [M*N-1:0][OWS-1:0]         mults_t;

  logic  clk       = 1'b0;
  logic  rst_n     = 1'b0;
  logic  in_valid  = 1'b0;
  logic  in_last   = 1'b0;
  logic  accum_en  = 1'b0;
  logic  out_ready = 1'b1;
  prod_t prod      = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matmul_adder_tree_pipe_if #(.DIM_M(M), .DIM_K(K), .DIM_N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW))  bus_m ();
  matmul_adder_tree_pipe_if #(.DIM_M(M), .DIM_K(K), .DIM_N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OWS)) bus_s ();
  matmul_adder_tree_pipe_if #(.DIM_M(M), .DIM_K(K), .DIM_N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OWS)) bus_w ();

  assign bus_m.in_valid = in_valid;  assign bus_s.in_valid = in_valid;  assign bus_w.in_valid = in_valid;
  assign bus_m.in_last  = in_last;   assign bus_s.in_last  = in_last;   assign bus_w.in_last  = in_last;
  assign bus_m.accum_en = accum_en;  assign bus_s.accum_en = accum_en;  assign bus_w.accum_en = accum_en;
  assign bus_m.out_ready = out_ready; assign bus_s.out_ready = out_ready; assign bus_w.out_ready = out_ready;
  assign bus_m.prod = prod;          assign bus_s.prod = prod;          assign bus_w.prod = prod;

  matmul_adder_tree_pipe #(.DIM_M(M), .DIM_K(K), .DIM_N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SAT_EN(1'b1))
    u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus_m));
  matmul_adder_tree_pipe #(.DIM_M(M), .DIM_K(K), .DIM_N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OWS), .SAT_EN(1'b1))
    u_sat  (.clk(clk), .rst_n(rst_n), .bus(bus_s));
  matmul_adder_tree_pipe #(.DIM_M(M), .DIM_K(K), .DIM_N(N), .ACC_WIDTH(AW), .OUT_WIDTH(OWS), .SAT_EN(1'b0))
    u_wrap (.clk(clk), .rst_n(rst_n), .bus(bus_w));

  function automatic prod_t fill(input int v);
    prod_t p;
    for (int a = 0; a < M*K; a++)
      for (int b = 0; b < K*N; b++) p[a][b] = AW'(v);
    return p;
  endfunction

  function automatic mult_t rep_m(input int v);
    mult_t r;
    for (int e = 0; e < M*N; e++) r[e] = OW'(v);
    return r;
  endfunction

  function automatic mults_t rep_s(input int v);
    mults_t r;
    for (int e = 0; e < M*N; e++) r[e] = OWS'(v);
    return r;
  endfunction

  // Presents one beat and returns 1 time unit after the edge that accepted it
  task automatic send_beat(input prod_t p, input logic last, input logic acc);
    int n;
    n = 0;
    @(negedge clk);
    prod = p; in_last = last; accum_en = acc; in_valid = 1'b1;
    while (bus_m.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (bus_m.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_accept: in_ready=%b required 1 within 50 cycles", bus_m.in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (bus_m.out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus_m.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus_m.out_valid); end
    n_checks++;
    if (bus_m.mult !== '0) begin n_fail++; $display("FAIL reset_mult: got %h required 0", bus_m.mult); end
    n_checks++;
    if (bus_m.beat_cnt !== 8'd0 || bus_m.sat_flag !== '0) begin
      n_fail++; $display("FAIL reset_cnt_flag: got cnt=%0d flag=%b required 0/0", bus_m.beat_cnt, bus_m.sat_flag);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus_m.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", bus_m.in_ready); end
  endtask

  task automatic test_single_beat;
    prod_t p;
    mult_t exp_m;
    int    cyc;
    p = '0;
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++) p[i*K+k][k*N+k] = AW'(i*K + k + 1);
    for (int e = 0; e < M*N; e++) exp_m[e] = OW'(e + 1);
    out_ready = 1'b1;
    send_beat(p, 1'b0, 1'b0);
    n_checks++;
    if (bus_m.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: out_valid=%b required 0", bus_m.out_valid); end
    wait_out(cyc);
    n_checks++;
    if (cyc + 1 !== 3) begin n_fail++; $display("FAIL single_latency: got %0d cycles required 3", cyc + 1); end
    n_checks++;
    if (bus_m.mult !== exp_m) begin n_fail++; $display("FAIL single_mult: got %h required %h", bus_m.mult, exp_m); end
    n_checks++;
    if (bus_m.beat_cnt !== 8'd1 || bus_m.sat_flag !== '0) begin
      n_fail++; $display("FAIL single_cnt_flag: got cnt=%0d flag=%b required 1/0", bus_m.beat_cnt, bus_m.sat_flag);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus_m.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: out_valid=%b required 0", bus_m.out_valid); end
  endtask

  task automatic test_accum_group;
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      send_beat(fill(1), (b == 2), 1'b1);
      n_checks++;
      if (bus_m.out_valid !== 1'b0) begin n_fail++; $display("FAIL group_early_b%0d: out_valid=%b required 0", b, bus_m.out_valid); end
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus_m.out_valid !== 1'b0) begin n_fail++; $display("FAIL group_early_b2: out_valid=%b required 0", bus_m.out_valid); end
    @(posedge clk); #1;
    n_checks++;
    if (bus_m.out_valid !== 1'b1 || bus_m.mult !== rep_m(9)) begin
      n_fail++; $display("FAIL group_result: valid=%b mult=%h required 1/%h", bus_m.out_valid, bus_m.mult, rep_m(9));
    end
    n_checks++;
    if (bus_m.beat_cnt !== 8'd3) begin n_fail++; $display("FAIL group_cnt: got %0d required 3", bus_m.beat_cnt); end
    @(posedge clk); #1;
    n_checks++;
    if (bus_m.out_valid !== 1'b0) begin n_fail++; $display("FAIL group_single_pulse: out_valid=%b required 0", bus_m.out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send_beat(fill(2), 1'b0, 1'b0);
    send_beat(fill(3), 1'b0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (bus_m.out_valid !== 1'b1 || bus_m.mult !== rep_m(6)) begin
      n_fail++; $display("FAIL bp_first: valid=%b mult=%h required 1/%h", bus_m.out_valid, bus_m.mult, rep_m(6));
    end
    prod = fill(1); in_last = 1'b0; accum_en = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus_m.in_ready !== 1'b0 || bus_m.out_valid !== 1'b1 || bus_m.mult !== rep_m(6)) begin
        n_fail++;
        $display("FAIL bp_hold_c%0d: in_ready=%b valid=%b mult=%h required 0/1/%h",
                 c, bus_m.in_ready, bus_m.out_valid, bus_m.mult, rep_m(6));
      end
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (bus_m.out_valid !== 1'b1 || bus_m.mult !== rep_m(9)) begin
      n_fail++; $display("FAIL bp_second: valid=%b mult=%h required 1/%h", bus_m.out_valid, bus_m.mult, rep_m(9));
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus_m.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_gap: out_valid=%b required 0", bus_m.out_valid); end
    @(posedge clk); #1;
    n_checks++;
    if (bus_m.out_valid !== 1'b1 || bus_m.mult !== rep_m(3)) begin
      n_fail++; $display("FAIL bp_third: valid=%b mult=%h required 1/%h", bus_m.out_valid, bus_m.mult, rep_m(3));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation;
    int cyc;
    out_ready = 1'b1;
    for (int b = 0; b < 12; b++) send_beat(fill(32767), (b == 11), 1'b1);
    wait_out(cyc);
    n_checks++;
    if (bus_m.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_timeout: out_valid=%b required 1", bus_m.out_valid); end
    n_checks++;
    if (bus_m.mult !== rep_m(1179612) || bus_m.sat_flag !== '0 || bus_m.beat_cnt !== 8'd12) begin
      n_fail++; $display("FAIL sat_wide: mult=%h flag=%b cnt=%0d required %h/0/12",
                         bus_m.mult, bus_m.sat_flag, bus_m.beat_cnt, rep_m(1179612));
    end
    n_checks++;
    if (bus_s.mult !== rep_s(524287) || bus_s.sat_flag !== '1) begin
      n_fail++; $display("FAIL sat_clamp: mult=%h flag=%b required %h/all-1", bus_s.mult, bus_s.sat_flag, rep_s(524287));
    end
    n_checks++;
    if (bus_w.mult !== rep_s(131036) || bus_w.sat_flag !== '1) begin
      n_fail++; $display("FAIL sat_wrap: mult=%h flag=%b required %h/all-1", bus_w.mult, bus_w.sat_flag, rep_s(131036));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_negative;
    int cyc;
    out_ready = 1'b1;
    send_beat(fill(-32768), 1'b0, 1'b0);
    wait_out(cyc);
    n_checks++;
    if (bus_m.out_valid !== 1'b1 || bus_m.mult !== rep_m(-98304) || bus_m.sat_flag !== '0) begin
      n_fail++; $display("FAIL neg_wide: valid=%b mult=%h flag=%b required 1/%h/0",
                         bus_m.out_valid, bus_m.mult, bus_m.sat_flag, rep_m(-98304));
    end
    n_checks++;
    if (bus_s.mult !== rep_s(-98304) || bus_s.sat_flag !== '0) begin
      n_fail++; $display("FAIL neg_narrow: mult=%h flag=%b required %h/0", bus_s.mult, bus_s.sat_flag, rep_s(-98304));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    fork
      begin : drive
        for (int b = 1; b <= 4; b++) send_beat(fill(b), 1'b0, 1'b0);
      end
      begin : monitor
        int cyc;
        wait_out(cyc);
        for (int b = 1; b <= 4; b++) begin
          n_checks++;
          if (bus_m.out_valid !== 1'b1 || bus_m.mult !== rep_m(3*b) || bus_m.beat_cnt !== 8'd1) begin
            n_fail++; $display("FAIL b2b_r%0d: valid=%b mult=%h cnt=%0d required 1/%h/1",
                               b, bus_m.out_valid, bus_m.mult, bus_m.beat_cnt, rep_m(3*b));
          end
          @(posedge clk); #1;
        end
        n_checks++;
        if (bus_m.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: out_valid=%b required 0", bus_m.out_valid); end
      end
    join
  endtask

  task automatic test_reset_mid_group;
    int cyc;
    out_ready = 1'b0;
    send_beat(fill(5), 1'b0, 1'b0);
    send_beat(fill(1), 1'b0, 1'b1);
    send_beat(fill(1), 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_m.out_valid !== 1'b0 || bus_m.mult !== '0 || bus_m.beat_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_clear: valid=%b mult=%h cnt=%0d required 0/0/0",
                         bus_m.out_valid, bus_m.mult, bus_m.beat_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    send_beat(fill(1), 1'b0, 1'b0);
    wait_out(cyc);
    n_checks++;
    if (bus_m.out_valid !== 1'b1 || bus_m.mult !== rep_m(3) || bus_m.beat_cnt !== 8'd1 || bus_m.sat_flag !== '0) begin
      n_fail++; $display("FAIL rstmid_fresh: valid=%b mult=%h cnt=%0d flag=%b required 1/%h/1/0",
                         bus_m.out_valid, bus_m.mult, bus_m.beat_cnt, bus_m.sat_flag, rep_m(3));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_accum_group();
    test_backpressure();
    test_saturation();
    test_negative();
    test_back_to_back();
    test_reset_mid_group();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion within 200000 time units");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/matmul_adder_tree_pipe.md
Name: matmul_adder_tree_pipe

Overview:
- Parametrised, pipelined successor to the fixed 3x3 TLUT product-reduction adder tree.
- Takes the full TLUT product array for an MxK by KxN tile and reduces it to MxN dot-product results.
- Reduction uses a registered binary adder tree with valid/ready backpressure.
- Adds optional multi-tile accumulation (K-dimension tiling) and optional signed saturation.
- Sits between the TLUT multiplier array and the result write-back/output buffer.

Parameters:
- DIM_M, 3, rows of operand 1 / result rows
- DIM_K, 3, inner dimension (terms summed per result)
- DIM_N, 3, columns of operand 2 / result columns
- ACC_WIDTH, 16, width of each signed product term
- OUT_WIDTH, 24, width of each signed accumulated result
- SAT_EN, 1, 1 = saturate on overflow, 0 = two's-complement wrap

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  product beat valid
- in_ready  out  1  block can accept a beat this cycle
- prod  in  [DIM_M*DIM_K][DIM_K*DIM_N][ACC_WIDTH]  signed product array; term (i,k,j) = prod[i*DIM_K+k][k*DIM_N+j]
- in_last  in  1  final K-tile of the current accumulation group
- accum_en  in  1  1 = add beat into running accumulation; 0 = beat is standalone (treated as last)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- mult  out  [DIM_M*DIM_N][OUT_WIDTH]  signed results, index i*DIM_N+j
- sat_flag  out  [DIM_M*DIM_N]  per-result flag: saturation/overflow occurred in this group
- beat_cnt  out  8  number of beats folded into the presented result (saturates at 255)

Behaviour:
- Reset (async, rst_n low): all pipeline valids, out_valid, mult, sat_flag, beat_cnt and accumulators cleared to 0. Any in-flight beats and partial accumulations are discarded. in_ready is 1 one cycle after reset release.
- Arithmetic: mult[i*N+j] = sum over the group of sum_k prod[i*K+k][k*N+j].
  - Terms are sign-extended to TREE_W = ACC_WIDTH+clog2(DIM_K).
  - The tree is exact (never overflows).
- Tree pipeline: L = max(1, clog2(DIM_K)) register stages; odd operands at a level pass through to the next level unmodified.
  - Each stage carries valid, last and accum_en sideband.
- Accumulate stage (1 register):
  - If the previous group closed (or after reset), acc = tree_sum sign-extended to OUT_WIDTH; otherwise acc = acc + tree_sum.
  - With SAT_EN=1, the result clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and sets the sticky sat_flag bit for the group.
  - With SAT_EN=0, the result wraps and sat_flag still flags overflow.
- Group close: a beat with in_last=1 or accum_en=0 closes the group.
  - Only a closing beat raises out_valid. Non-closing beats update acc silently.
  - beat_cnt is the count of beats in the group.
- Latency: closing beat accepted at cycle T -> out_valid at T+L+1 with no stall. Throughput is 1 beat/cycle.
- Handshake: global stall with en = !out_valid | out_ready; in_ready = en.
  - Beat accepted when in_valid & in_ready.
  - Pipeline advances only when en=1.
  - mult, sat_flag and beat_cnt are held stable while out_valid & !out_ready.
  - When out_valid & out_ready, the next group's accumulation starts cleanly in the same cycle.
- Bubbles: in_valid=0 cycles insert invalid stages; partial accumulations are unaffected.
- prod is don't-care when in_valid=0.

Test Plan:
- Single beat, M=K=N=3, A=[[1,2,3],[4,5,6],[7,8,9]], B=identity products, accum_en=0, out_ready=1 -> mult=[1,2,3,4,5,6,7,8,9] exactly L+1=3 cycles after acceptance, beat_cnt=1, sat_flag=0.
- Three-beat group, every product term=1, in_last on third beat -> single out_valid pulse with all mult=9, beat_cnt=3; no out_valid on beats 1-2.
- Backpressure: hold out_ready=0 for 5 cycles with a result pending -> in_ready=0, mult stable, no beats lost. Release -> next result follows on the following cycle.
- Saturation, OUT_WIDTH=20, all terms=32767, 12-beat group -> mult=524287 and sat_flag=1 on all elements. Same with SAT_EN=0 -> wrapped value and sat_flag=1.
- Negative terms: all terms=-32768, single beat -> mult=-98304 on every element, no flag.
- Reset asserted mid-group (after 2 of 3 beats) -> out_valid=0 immediately. A fresh single beat of all 1s then yields mult=3, beat_cnt=1.
